// File: rtl/conv_window_sched_if.sv
// Handshake bundle between the window scheduler and its neighbours: job control,
// SRAM bank status, register-array loader and OPU beat port.
interface conv_window_sched_if #(
  parameter int CW = 9
);
  logic                 START;
  logic                 ABORT;
  logic [7:0]           PIC_SIZE;
  logic                 PADDING;
  logic                 BANK_RDY;
  logic                 LD_REQ;
  logic                 LD_ACK;
  logic signed [CW-1:0] WIN_X;
  logic signed [CW-1:0] WIN_Y;
  logic [2:0]           BIT_IDX;
  logic                 OPU_VLD;
  logic                 OPU_RDY;
  logic                 BUSY;
  logic                 DONE;
  logic                 CFG_ERR;
  logic [15:0]          WIN_CNT;

  modport master (
    input  START, ABORT, PIC_SIZE, PADDING, BANK_RDY, LD_ACK, OPU_RDY,
    output LD_REQ, WIN_X, WIN_Y, BIT_IDX, OPU_VLD, BUSY, DONE, CFG_ERR, WIN_CNT
  );

  modport slave (
    output START, ABORT, PIC_SIZE, PADDING, BANK_RDY, LD_ACK, OPU_RDY,
    input  LD_REQ, WIN_X, WIN_Y, BIT_IDX, OPU_VLD, BUSY, DONE, CFG_ERR, WIN_CNT
  );
endinterface

// File: rtl/conv_window_sched.sv
// 3x3 window sequencer: walks window positions in two-column serpentine strips,
// issuing one register-array load and eight bit-plane OPU beats per window.
module conv_window_sched #(
  parameter int MAXP = 64,
  parameter int CW   = 9
) (
  input logic                  SYS_CLK,
  input logic                  SYS_NRST,
  conv_window_sched_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_BANK = 3'd1,
    S_LOAD      = 3'd2,
    S_BEAT      = 3'd3,
    S_FIN       = 3'd4
  } state_t;

  localparam logic [8:0] MAXP_W = 9'(MAXP);

  state_t               state_q, state_d;
  logic [7:0]           n_q, n_d;
  logic                 pad_q, pad_d;
  logic [6:0]           strip_q, strip_d;
  logic [7:0]           w_q, w_d;
  logic [2:0]           bit_q, bit_d;
  logic [15:0]          win_cnt_q, win_cnt_d;
  logic signed [CW-1:0] win_x_q, win_x_d;
  logic signed [CW-1:0] win_y_q, win_y_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 busy_q, busy_d;
  logic                 ld_req_q, ld_req_d;
  logic                 opu_vld_q, opu_vld_d;
  logic                 done_q, done_d;

  logic [8:0] n_calc;
  logic       cfg_legal;
  logic       last_w;
  logic       last_strip;
  logic       last_win;
  logic       beat_last;
  logic [6:0] r_d;
  logic       c_d;

  // Positions per axis; only meaningful once PIC_SIZE >= 4 is also satisfied.
  assign n_calc     = {1'b0, bus.PIC_SIZE} + {7'd0, bus.PADDING, 1'b0} - 9'd2;
  assign cfg_legal  = !bus.PIC_SIZE[0] && (bus.PIC_SIZE >= 8'd4) &&
                      ({1'b0, bus.PIC_SIZE} <= MAXP_W) && (n_calc >= 9'd2);
  assign last_w     = (w_q == ({n_q[6:0], 1'b0} - 8'd1));
  assign last_strip = (strip_q == (n_q[7:1] - 7'd1));
  assign last_win   = last_w && last_strip;
  assign beat_last  = (state_q == S_BEAT) && bus.OPU_RDY && (bit_q == 3'd7);

  always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      pad_q     <= 1'b0;
      strip_q   <= '0;
      w_q       <= '0;
      bit_q     <= '0;
      win_cnt_q <= '0;
      win_x_q   <= '0;
      win_y_q   <= '0;
      cfg_err_q <= 1'b0;
      busy_q    <= 1'b0;
      ld_req_q  <= 1'b0;
      opu_vld_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      pad_q     <= pad_d;
      strip_q   <= strip_d;
      w_q       <= w_d;
      bit_q     <= bit_d;
      win_cnt_q <= win_cnt_d;
      win_x_q   <= win_x_d;
      win_y_q   <= win_y_d;
      cfg_err_q <= cfg_err_d;
      busy_q    <= busy_d;
      ld_req_q  <= ld_req_d;
      opu_vld_q <= opu_vld_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (bus.START && cfg_legal) state_d = S_WAIT_BANK;
      S_WAIT_BANK: if (bus.BANK_RDY) state_d = S_LOAD;
      S_LOAD:      if (bus.LD_ACK) state_d = S_BEAT;
      S_BEAT:      if (beat_last) state_d = last_win ? S_FIN : S_LOAD;
      S_FIN:       state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    if (bus.ABORT) state_d = S_IDLE;
  end

  // Window counters and latched job configuration.
  always_comb begin
    n_d       = n_q;
    pad_d     = pad_q;
    strip_d   = strip_q;
    w_d       = w_q;
    bit_d     = bit_q;
    win_cnt_d = win_cnt_q;
    cfg_err_d = 1'b0;
    if (!bus.ABORT) begin
      case (state_q)
        S_IDLE: begin
          if (bus.START) begin
            if (cfg_legal) begin
              n_d       = n_calc[7:0];
              pad_d     = bus.PADDING;
              strip_d   = '0;
              w_d       = '0;
              bit_d     = '0;
              win_cnt_d = '0;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        S_LOAD: if (bus.LD_ACK) bit_d = 3'd0;
        S_BEAT: begin
          if (bus.OPU_RDY) begin
            if (bit_q != 3'd7) begin
              bit_d = bit_q + 3'd1;
            end else begin
              bit_d     = 3'd0;
              win_cnt_d = win_cnt_q + 16'd1;
              if (!last_win) begin
                if (last_w) begin
                  w_d     = '0;
                  strip_d = strip_q + 7'd1;
                end else begin
                  w_d = w_q + 8'd1;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
    // Serpentine: odd rows of a strip visit the right column first.
    r_d     = w_d[7:1];
    c_d     = w_d[0] ^ r_d[0];
    win_x_d = CW'({strip_d, 1'b0}) + CW'(c_d) - CW'(pad_d);
    win_y_d = CW'(r_d) - CW'(pad_d);
  end

  always_comb begin
    busy_d    = (state_d != S_IDLE);
    ld_req_d  = (state_d == S_LOAD);
    opu_vld_d = (state_d == S_BEAT);
    done_d    = (state_d == S_FIN);
  end

  assign bus.LD_REQ  = ld_req_q;
  assign bus.OPU_VLD = opu_vld_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.CFG_ERR = cfg_err_q;
  assign bus.WIN_X   = win_x_q;
  assign bus.WIN_Y   = win_y_q;
  assign bus.BIT_IDX = bit_q;
  assign bus.WIN_CNT = win_cnt_q;

endmodule

// File: tb/tb_conv_window_sched.sv
// Self-checking bench for conv_window_sched: table of job configs, randomized
// handshakes, and a window-list model built straight from the strip rules.
module tb_conv_window_sched;
  localparam int CW = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_window_sched_if #(.CW(CW)) bus ();

  conv_window_sched #(.MAXP(64), .CW(CW)) dut (
    .SYS_CLK (clk),
    .SYS_NRST(rst_n),
    .bus     (bus)
  );

  typedef struct {
    int pic;
    int pad;
    int mode;
    int bank_delay;
    int exp_err;
    int exp_win;
  } vec_t;

  vec_t vecs[$];

  int checks = 0;
  int failures = 0;
  int fail_prints = 0;

  int beat_x[$];
  int beat_y[$];
  int beat_b[$];
  int loads, done_cnt, load_x, load_y;
  bit mon_en = 1'b0;
  bit prev_stall = 1'b0;
  logic [2*CW+3:0] prev_out;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (fail_prints < 50) begin
        fail_prints++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshakes are sampled mid-cycle; inputs are only changed just after posedge.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (prev_stall)
        chk("stall_hold", int'({bus.OPU_VLD, bus.WIN_X, bus.WIN_Y, bus.BIT_IDX} == prev_out), 1);
      prev_stall = bus.OPU_VLD && !bus.OPU_RDY;
      prev_out   = {bus.OPU_VLD, bus.WIN_X, bus.WIN_Y, bus.BIT_IDX};
      if (bus.LD_REQ && bus.LD_ACK) begin
        loads++;
        load_x = int'(bus.WIN_X);
        load_y = int'(bus.WIN_Y);
      end
      if (bus.OPU_VLD && bus.OPU_RDY) begin
        beat_x.push_back(int'(bus.WIN_X));
        beat_y.push_back(int'(bus.WIN_Y));
        beat_b.push_back(int'(bus.BIT_IDX));
        chk("beat_coord_matches_load", int'(int'(bus.WIN_X) == load_x && int'(bus.WIN_Y) == load_y), 1);
      end
      if (bus.DONE) done_cnt++;
    end
  end

  task automatic chk_win(input string name, input int idx, input int x, input int y);
    if (idx * 8 < beat_x.size()) begin
      chk({name, "_x"}, beat_x[idx*8], x);
      chk({name, "_y"}, beat_y[idx*8], y);
    end else begin
      chk({name, "_present"}, 0, 1);
    end
  endtask

  task automatic run_job(input int pic, input int pad, input int mode, input int bank_delay,
                         output int cfg_seen);
    int  n;
    int  exp_x[$];
    int  exp_y[$];
    bit  legal;
    int  stall_cnt, bank_bad, nb;
    bit  done_seen;
    n     = pic - 2 + 2 * pad;
    legal = (pic % 2 == 0) && (pic >= 4) && (pic <= 64) && (n >= 2);
    if (legal) begin
      for (int s = 0; s < n / 2; s++) begin
        for (int w = 0; w < 2 * n; w++) begin
          int r, c;
          r = w / 2;
          c = (w % 2) ^ (r % 2);
          exp_x.push_back(2 * s - pad + c);
          exp_y.push_back(r - pad);
        end
      end
    end
    beat_x.delete(); beat_y.delete(); beat_b.delete();
    loads = 0; done_cnt = 0; prev_stall = 1'b0; load_x = 0; load_y = 0;
    mon_en = 1'b1;
    bus.PIC_SIZE = 8'(pic);
    bus.PADDING  = 1'(pad);
    bus.BANK_RDY = (bank_delay == 0);
    bus.OPU_RDY  = 1'b0;
    bus.LD_ACK   = 1'b0;
    bus.START    = 1'b1;
    tick();
    bus.START = 1'b0;
    cfg_seen  = int'(bus.CFG_ERR);
    if (!legal) begin
      chk("bad_cfg_err", int'(bus.CFG_ERR), 1);
      chk("bad_cfg_busy", int'(bus.BUSY), 0);
      tick();
      chk("bad_cfg_err_one_cycle", int'(bus.CFG_ERR), 0);
      chk("bad_cfg_busy_after", int'(bus.BUSY), 0);
      mon_en = 1'b0;
      return;
    end
    chk("start_cfg_err", int'(bus.CFG_ERR), 0);
    chk("start_busy_k1", int'(bus.BUSY), 1);
    chk("start_ldreq_k1", int'(bus.LD_REQ), 0);
    // Config changes and a second START mid-job must be ignored.
    bus.PIC_SIZE = 8'($urandom_range(0, 255));
    bus.PADDING  = 1'($urandom_range(0, 1));
    bus.START    = 1'b1;
    tick();
    bus.START = 1'b0;
    chk("start_while_busy_cfg_err", int'(bus.CFG_ERR), 0);
    if (bank_delay == 0) chk("start_ldreq_k2", int'(bus.LD_REQ), 1);
    bank_bad = 0; stall_cnt = 0; done_seen = 1'b0;
    for (int cyc = 2; cyc < 40000; cyc++) begin
      if (!bus.BANK_RDY && (!bus.BUSY || bus.LD_REQ || bus.OPU_VLD)) bank_bad++;
      if (bus.DONE) begin
        done_seen = 1'b1;
        break;
      end
      bus.BANK_RDY = (cyc >= bank_delay);
      case (mode)
        0: begin
          bus.OPU_RDY = 1'b1;
          bus.LD_ACK  = bus.LD_REQ;
        end
        1: begin
          bus.OPU_RDY = 1'($urandom_range(0, 1));
          bus.LD_ACK  = bus.LD_REQ ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
        end
        default: begin
          bus.LD_ACK = bus.LD_REQ;
          if (bus.OPU_VLD) begin
            if (stall_cnt == 20) begin
              bus.OPU_RDY = 1'b1;
              stall_cnt   = 0;
            end else begin
              bus.OPU_RDY = 1'b0;
              stall_cnt++;
            end
          end else begin
            bus.OPU_RDY = 1'b0;
          end
        end
      endcase
      tick();
    end
    chk("job_done_seen", int'(done_seen), 1);
    bus.LD_ACK = 1'b0;
    bus.OPU_RDY = 1'b0;
    tick();
    chk("busy_after_done", int'(bus.BUSY), 0);
    chk("done_one_cycle", int'(bus.DONE), 0);
    bus.BANK_RDY = 1'b0;
    tick();
    mon_en = 1'b0;
    if (bank_delay > 0) chk("bank_wait_idle_outputs", bank_bad, 0);
    chk("done_count", done_cnt, 1);
    chk("win_cnt", int'(bus.WIN_CNT), n * n);
    chk("load_count", loads, n * n);
    chk("beat_count", beat_x.size(), 8 * n * n);
    nb = beat_x.size();
    if (nb > 8 * exp_x.size()) nb = 8 * exp_x.size();
    for (int i = 0; i < nb; i++) begin
      chk($sformatf("seq_x[%0d]", i), beat_x[i], exp_x[i/8]);
      chk($sformatf("seq_y[%0d]", i), beat_y[i], exp_y[i/8]);
      chk($sformatf("seq_bit[%0d]", i), beat_b[i], i % 8);
    end
    $display("job pic=%0d pad=%0d mode=%0d bank_delay=%0d windows=%0d beats=%0d",
             pic, pad, mode, bank_delay, int'(bus.WIN_CNT), beat_x.size());
  endtask

  task automatic add_vec(input int pic, input int pad, input int mode, input int bd,
                         input int err, input int nwin);
    vec_t v;
    v.pic = pic; v.pad = pad; v.mode = mode; v.bank_delay = bd;
    v.exp_err = err; v.exp_win = nwin;
    vecs.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got 0 expected 1 (simulation time limit)");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cfg_seen;
    int bad;
    bit hit;

    add_vec(8, 1, 1, 0, 0, 64);
    add_vec(8, 0, 1, 0, 0, 36);
    add_vec(7, 0, 1, 0, 1, 0);
    add_vec(2, 1, 1, 0, 1, 0);
    add_vec(4, 0, 1, 0, 0, 4);
    add_vec(4, 1, 1, 3, 0, 16);
    add_vec(6, 1, 1, 0, 0, 36);
    add_vec(0, 0, 1, 0, 1, 0);
    add_vec(66, 1, 1, 0, 1, 0);
    add_vec(3, 1, 1, 0, 1, 0);
    add_vec(10, 0, 1, 2, 0, 64);

    bus.START = 1'b0; bus.ABORT = 1'b0; bus.PIC_SIZE = 8'd0; bus.PADDING = 1'b0;
    bus.BANK_RDY = 1'b0; bus.LD_ACK = 1'b0; bus.OPU_RDY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(bus.BUSY), 0);
    chk("rst_ld_req", int'(bus.LD_REQ), 0);
    chk("rst_opu_vld", int'(bus.OPU_VLD), 0);
    chk("rst_done", int'(bus.DONE), 0);
    chk("rst_cfg_err", int'(bus.CFG_ERR), 0);
    chk("rst_win_x", int'(bus.WIN_X), 0);
    chk("rst_win_y", int'(bus.WIN_Y), 0);
    chk("rst_bit_idx", int'(bus.BIT_IDX), 0);
    chk("rst_win_cnt", int'(bus.WIN_CNT), 0);
    rst_n = 1'b1;
    tick();

    // Cycle-exact start, first window and abort at window 10 beat 3.
    bus.PIC_SIZE = 8'd8; bus.PADDING = 1'b1; bus.BANK_RDY = 1'b1; bus.OPU_RDY = 1'b1;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    chk("t_busy_k1", int'(bus.BUSY), 1);
    chk("t_ldreq_k1", int'(bus.LD_REQ), 0);
    tick();
    chk("t_ldreq_k2", int'(bus.LD_REQ), 1);
    chk("t_first_x", int'(bus.WIN_X), -1);
    chk("t_first_y", int'(bus.WIN_Y), -1);
    bus.LD_ACK = 1'b1;
    tick();
    bus.LD_ACK = 1'b0;
    chk("t_ack_ldreq", int'(bus.LD_REQ), 0);
    chk("t_ack_vld", int'(bus.OPU_VLD), 1);
    chk("t_ack_bit", int'(bus.BIT_IDX), 0);
    for (int b = 1; b < 8; b++) begin
      tick();
      chk($sformatf("t_beat_bit%0d", b), int'(bus.BIT_IDX), b);
      chk($sformatf("t_beat_vld%0d", b), int'(bus.OPU_VLD), 1);
    end
    tick();
    chk("t_next_vld", int'(bus.OPU_VLD), 0);
    chk("t_next_ldreq", int'(bus.LD_REQ), 1);
    chk("t_next_x", int'(bus.WIN_X), 0);
    chk("t_next_y", int'(bus.WIN_Y), -1);
    chk("t_next_cnt", int'(bus.WIN_CNT), 1);
    hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bus.LD_ACK = bus.LD_REQ;
      if (bus.OPU_VLD && bus.WIN_CNT == 16'd10 && bus.BIT_IDX == 3'd3) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    chk("abort_reached", int'(hit), 1);
    bus.ABORT = 1'b1;
    bus.LD_ACK = 1'b0;
    tick();
    bus.ABORT = 1'b0;
    chk("abort_vld", int'(bus.OPU_VLD), 0);
    chk("abort_busy", int'(bus.BUSY), 0);
    chk("abort_ldreq", int'(bus.LD_REQ), 0);
    chk("abort_done", int'(bus.DONE), 0);
    bad = 0;
    repeat (10) begin
      tick();
      if (bus.DONE || bus.BUSY) bad++;
    end
    chk("abort_quiet", bad, 0);
    bus.OPU_RDY = 1'b0; bus.BANK_RDY = 1'b0;

    run_job(8, 1, 0, 0, cfg_seen);
    chk_win("p1_w0", 0, -1, -1);
    chk_win("p1_w1", 1, 0, -1);
    chk_win("p1_w2", 2, 0, 0);
    chk_win("p1_w3", 3, -1, 0);
    chk_win("p1_w4", 4, -1, 1);
    chk_win("p1_strip0_end", 15, -1, 6);
    chk_win("p1_strip1_start", 16, 1, -1);
    chk_win("p1_last", 63, 5, 6);

    run_job(8, 0, 0, 0, cfg_seen);
    chk_win("p0_first", 0, 0, 0);
    chk_win("p0_last", 35, 4, 5);

    foreach (vecs[i]) begin
      run_job(vecs[i].pic, vecs[i].pad, vecs[i].mode, vecs[i].bank_delay, cfg_seen);
      chk($sformatf("tbl%0d_cfg_err", i), cfg_seen, vecs[i].exp_err);
      if (vecs[i].exp_err == 0) chk($sformatf("tbl%0d_win_cnt", i), int'(bus.WIN_CNT), vecs[i].exp_win);
      else chk($sformatf("tbl%0d_busy", i), int'(bus.BUSY), 0);
    end

    run_job(4, 1, 2, 0, cfg_seen);
    run_job(4, 1, 1, 50, cfg_seen);

    // Reset mid-job returns to reset values at once.
    bus.PIC_SIZE = 8'd8; bus.PADDING = 1'b0; bus.BANK_RDY = 1'b1; bus.OPU_RDY = 1'b1;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    repeat (60) begin
      bus.LD_ACK = bus.LD_REQ;
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(bus.BUSY), 0);
    chk("mid_rst_vld_ldreq", int'(bus.OPU_VLD || bus.LD_REQ), 0);
    chk("mid_rst_win_cnt", int'(bus.WIN_CNT), 0);
    chk("mid_rst_bit", int'(bus.BIT_IDX), 0);
    chk("mid_rst_xy", int'(bus.WIN_X != 0 || bus.WIN_Y != 0), 0);
    bus.LD_ACK = 1'b0; bus.OPU_RDY = 1'b0; bus.BANK_RDY = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", int'(bus.BUSY), 0);
    run_job(8, 0, 1, 0, cfg_seen);
    chk_win("post_rst_first", 0, 0, 0);

    for (int j = 0; j < 6; j++) begin
      run_job(int'($urandom_range(0, 12)), int'($urandom_range(0, 1)), 1,
              int'($urandom_range(0, 5)), cfg_seen);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv_window_sched.md
# conv_window_sched

Sequencer for the 3x3 convolution window datapath. After a picture has been stored into the active SRAM bank, it walks every 3x3 window position in strip-serpentine order. For each window it issues one register-array load, then eight bit-plane transfers to the OPU 1152-bit port. It sits between the SRAM bank status logic, the SRAM-to-register-array loader and the OPU handshake.

## Interface
- MAXP, 64: largest legal PIC_SIZE.
- CW, 9: width of the signed window coordinate outputs.
- SYS_CLK  in  1  single clock; all logic rises on it.
- SYS_NRST  in  1  asynchronous active-low reset.
- START  in  1  one-cycle job request; honoured only in IDLE.
- ABORT  in  1  synchronous job cancel.
- PIC_SIZE  in  8  picture edge in pixels; latched at START.
- PADDING  in  1  1 = zero-pad border of 1 pixel; latched at START.
- BANK_RDY  in  1  level; the picture is fully written in the active bank.
- LD_REQ  out  1  register-array load request, held until LD_ACK.
- LD_ACK  in  1  one-cycle completion from the loader.
- WIN_X, WIN_Y  out  CW  signed top-left coordinate of the current window.
- BIT_IDX  out  3  current bit-plane, 0 = LSB.
- OPU_VLD  out  1  OPU beat valid.
- OPU_RDY  in  1  OPU beat accept.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse after the last beat of the job.
- CFG_ERR  out  1  one-cycle pulse when a START is rejected.
- WIN_CNT  out  16  count of windows completed in the current job.

## Operation
- Positions per axis: N = PIC_SIZE − 2 + 2·PADDING. The job is legal iff PIC_SIZE is even, 4 ≤ PIC_SIZE ≤ MAXP, and N ≥ 2.
- An illegal START pulses CFG_ERR on the next cycle and the block stays in IDLE.
- Strips: s = 0 .. N/2−1, with x0 = 2s − PADDING. Each strip holds 2N windows.
- Within a strip, window w uses r = w>>1 and c = (w&1) XOR (r&1). The window is WIN_X = x0 + c, WIN_Y = r − PADDING.
- Resulting order: (x0,y0), (x0+1,y0), (x0+1,y0+1), (x0,y0+1), (x0,y0+2), …
- Total windows per job: N².
- States:
  - IDLE: START with a legal config latches the config, clears counters and goes to WAIT_BANK.
  - WAIT_BANK: BANK_RDY moves to LOAD.
  - LOAD: LD_REQ = 1. LD_ACK moves to BEAT with BIT_IDX = 0.
  - BEAT: OPU_VLD = 1. On OPU_VLD & OPU_RDY:
    - if BIT_IDX < 7, BIT_IDX increments and OPU_VLD stays high;
    - if BIT_IDX = 7, WIN_CNT increments and the block goes to FIN if this was the last window, otherwise it advances the window and goes to LOAD.
  - FIN: DONE = 1 for one cycle, then IDLE.
- WIN_X, WIN_Y and BIT_IDX stay stable while OPU_VLD is high without OPU_RDY.
- WIN_X and WIN_Y stay stable from LOAD entry through the window's final beat.
- Coordinates are two's complement. −1 appears only when PADDING = 1.
- ABORT has priority in every state: the next state is IDLE, OPU_VLD and LD_REQ drop without a handshake, and DONE is not pulsed.
- START while BUSY is ignored, with no CFG_ERR.
- PIC_SIZE and PADDING changes mid-job have no effect; both are latched only at START.
- An LD_ACK arriving outside LOAD is ignored.

## Timing
- Reset values: LD_REQ, OPU_VLD, BUSY, DONE and CFG_ERR are 0. WIN_X, WIN_Y, BIT_IDX and WIN_CNT are 0. State is IDLE.
- Reset asserted mid-job returns the block to these values immediately. No resume.
- START sampled in cycle k: BUSY = 1 from k+1. If BANK_RDY is already high, LD_REQ = 1 from k+2.
- LD_ACK in cycle m: LD_REQ = 0 and OPU_VLD = 1 from m+1.
- Back-to-back beats: with OPU_RDY tied high, the 8 bit-planes take 8 consecutive cycles.
- Handshake on bit 7 in cycle t:
  - if not the last window: OPU_VLD = 0 and LD_REQ = 1 at t+1 with the new coordinates;
  - if the last window: DONE = 1 at t+1, BUSY = 0 at t+2.
- Minimum per window with a zero-wait loader: 1 load cycle plus 8 beat cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- PIC_SIZE = 8, PADDING = 1, ready/ack always immediate:
  - 64 windows and 512 beats, DONE once, WIN_CNT = 64;
  - first five windows: (−1,−1), (0,−1), (0,0), (−1,0), (−1,1);
  - strip 0 ends at (−1,6), strip 1 starts at (1,−1);
  - last window is (5,6).
- PIC_SIZE = 8, PADDING = 0: 36 windows; first window (0,0); last window (4,5).
- OPU_RDY stalls of 20 cycles per beat: outputs hold during each stall, BIT_IDX sequence is 0..7 per window, no beat is lost or duplicated.
- BANK_RDY held low for 50 cycles after START: BUSY = 1 and LD_REQ = 0 throughout, then normal run once BANK_RDY rises.
- PIC_SIZE = 7 or PIC_SIZE = 2: CFG_ERR pulses once, BUSY stays 0; a START during BUSY is ignored.
- ABORT during window 10, beat 3: OPU_VLD = 0 next cycle, IDLE, no DONE. A new START then runs fully from (−1,−1). SYS_NRST mid-job gives the same return to IDLE.
